// File: rtl/cdc_handshake_rx.sv
// rtl/cdc_handshake_rx.sv - destination-side receiver for a toggle-based multi-bit CDC transfer
//
// Purpose:
//   The source sends a word by toggling its request line while holding the
//   data bus steady. This block sees that toggle, captures the word and offers
//   it on a valid/ready port. When the consumer takes the word, it toggles the
//   registered acknowledge line back to the source. It also counts completed
//   handshakes and sets a sticky error flag if the source toggles again before
//   it has received its acknowledge.
//
// Ports:
//   clk_in_b      destination clock; all state updates on its rising edge
//   arst_master   asynchronous, active-high reset
//   req_sync_i    request toggle, already 2-flop synchronized into clk_in_b
//   data_a_i      source data bus, quasi-static while a request is pending
//   data_o        captured word, registered, held until the next capture
//   valid_o       data_o holds an unconsumed word
//   ready_i       consumer accepts data_o when valid_o is high
//   ack_b_o       registered acknowledge toggle back to the source domain
//   xfer_count_o  completed handshakes, modulo 2^CNT_WIDTH
//   err_o         sticky protocol-violation flag

module cdc_handshake_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_in_b,
  input  logic                  arst_master,
  input  logic                  req_sync_i,
  input  logic [DATA_WIDTH-1:0] data_a_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  ack_b_o,
  output logic [CNT_WIDTH-1:0]  xfer_count_o,
  output logic                  err_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  req_seen;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  ack_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  err_q;

  logic                  capture;
  logic                  accept;
  logic                  violation;

  // The request is a toggle, so any difference from the last accepted
  // level means a new word is waiting on the bus.
  logic                  req_pending;
  assign req_pending = (req_sync_i != req_seen);

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    accept     = 1'b0;
    violation  = 1'b0;
    case (state)
      IDLE: begin
        // ready_i has no effect here.
        if (req_pending) begin
          capture    = 1'b1;
          state_next = VALID;
        end
      end
      VALID: begin
        // The source must not toggle again before it sees our ack. If it does,
        // we flag it but still finish the current word. The new toggle is
        // still pending, so it is captured after the return to IDLE.
        if (req_pending) begin
          violation = 1'b1;
        end
        if (ready_i) begin
          accept     = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in_b or posedge arst_master) begin
    if (arst_master) begin
      state    <= IDLE;
      req_seen <= 1'b0;
      data_q   <= '0;
      ack_q    <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (capture) begin
        data_q   <= data_a_i;
        req_seen <= req_sync_i;
      end
      if (accept) begin
        ack_q <= ~ack_q;
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
      if (violation) begin
        err_q <= 1'b1;
      end
    end
  end

  // valid_o is decoded only from the state flop. It has no path from the
  // inputs, and it drops as soon as reset is asserted.
  assign valid_o      = (state == VALID);
  assign data_o       = data_q;
  assign ack_b_o      = ack_q;
  assign xfer_count_o = cnt_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// tb/tb_cdc_handshake_rx.sv - self-checking bench for cdc_handshake_rx
//
// Purpose:
//   This bench models the source side at the level of words. It keeps a
//   handshake count, the expected word, and a sticky error expectation. The
//   expected ack level is the parity of the handshake count, and the expected
//   counter is the handshake count modulo 2^CNT_WIDTH. A 4-bit-counter copy
//   of the DUT shares all inputs, so counter wrap is exercised as well.
//
// Ports: none (top-level bench).

module tb_cdc_handshake_rx;

  logic       clk_in_b = 1'b0;
  logic       arst_master = 1'b1;
  logic       req_sync_i = 1'b0;
  logic [7:0] data_a_i = 8'h00;
  logic       ready_i = 1'b0;

  logic [7:0]  data_o;
  logic        valid_o;
  logic        ack_b_o;
  logic [15:0] xfer_count_o;
  logic        err_o;

  logic [7:0]  data_w;
  logic        valid_w;
  logic        ack_w;
  logic [3:0]  count_w;
  logic        err_w;

  int tests = 0;
  int fails = 0;
  int n     = 0;   // handshakes since the last reset
  bit err_exp = 1'b0;

  cdc_handshake_rx #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk_in_b     (clk_in_b),
    .arst_master  (arst_master),
    .req_sync_i   (req_sync_i),
    .data_a_i     (data_a_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .ack_b_o      (ack_b_o),
    .xfer_count_o (xfer_count_o),
    .err_o        (err_o)
  );

  cdc_handshake_rx #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_w (
    .clk_in_b     (clk_in_b),
    .arst_master  (arst_master),
    .req_sync_i   (req_sync_i),
    .data_a_i     (data_a_i),
    .data_o       (data_w),
    .valid_o      (valid_w),
    .ready_i      (ready_i),
    .ack_b_o      (ack_w),
    .xfer_count_o (count_w),
    .err_o        (err_w)
  );

  always #5 clk_in_b = ~clk_in_b;

  // All stimulus and sampling happen on the falling edge, away from the
  // rising edge where the DUT updates.
  //
  // One source transfer. The source toggles req with the word on the bus.
  // It optionally holds ready high from the start, or applies bp cycles of
  // backpressure. After the ack it waits two cycles, which stands in for the
  // source-side ack synchronizer round trip.
  task automatic do_xfer(input logic [7:0] w, input int bp, input bit ready_early);
    logic [7:0]  d16;
    @(negedge clk_in_b);
    data_a_i   = w;
    req_sync_i = ~req_sync_i;
    ready_i    = ready_early;
    tests++;
    if (valid_o !== 1'b0) begin
      fails++; $display("FAIL pre_capture_valid: got %0b want 0", valid_o);
    end
    @(negedge clk_in_b);
    tests++;
    if (valid_o !== 1'b1 || data_o !== w || valid_w !== 1'b1) begin
      fails++; $display("FAIL capture: valid %0b data %02h want valid 1 data %02h", valid_o, data_o, w);
    end
    if (!ready_early) begin
      for (int i = 0; i < bp; i++) begin
        @(negedge clk_in_b);
        tests++;
        if (valid_o !== 1'b1 || data_o !== w || ack_b_o !== n[0]) begin
          fails++;
          $display("FAIL backpressure_hold: valid %0b data %02h ack %0b want 1 %02h %0b",
                   valid_o, data_o, ack_b_o, w, n[0]);
        end
      end
      ready_i = 1'b1;
      @(negedge clk_in_b);
    end else begin
      @(negedge clk_in_b);
    end
    n++;
    d16 = data_o;
    tests++;
    if (valid_o !== 1'b0 || ack_b_o !== n[0] || xfer_count_o !== 16'(n) ||
        count_w !== 4'(n) || ack_w !== n[0] || d16 !== w || err_o !== err_exp) begin
      fails++;
      $display("FAIL accept: valid %0b ack %0b cnt %0d cnt4 %0d data %02h err %0b want 0 %0b %0d %0d %02h %0b",
               valid_o, ack_b_o, xfer_count_o, count_w, d16, err_o,
               n[0], 16'(n), 4'(n), w, err_exp);
    end
    ready_i = 1'b0;
    repeat (2) @(negedge clk_in_b);
  endtask

  task automatic apply_reset();
    @(negedge clk_in_b);
    arst_master = 1'b1;
    req_sync_i  = 1'b0;
    ready_i     = 1'b0;
    @(negedge clk_in_b);
    arst_master = 1'b0;
    n = 0;
    err_exp = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk_in_b);
    tests++;
    if (valid_o !== 1'b0 || ack_b_o !== 1'b0 || xfer_count_o !== 16'd0 ||
        err_o !== 1'b0 || data_o !== 8'h00 || count_w !== 4'd0) begin
      fails++;
      $display("FAIL reset_values: valid %0b ack %0b cnt %0d err %0b data %02h want all 0",
               valid_o, ack_b_o, xfer_count_o, err_o, data_o);
    end
  endtask

  task automatic test_single();
    do_xfer(8'hA5, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    do_xfer(8'h3C, 5, 1'b0);
  endtask

  task automatic test_back_to_back();
    int start;
    start = n;
    for (int k = 1; k <= 4; k++) do_xfer(8'(k), 0, 1'b0);
    tests++;
    if (ack_b_o !== 1'b0 || xfer_count_o !== 16'(start + 4) || err_o !== 1'b0) begin
      fails++;
      $display("FAIL back_to_back_end: ack %0b cnt %0d err %0b want 0 %0d 0",
               ack_b_o, xfer_count_o, err_o, start + 4);
    end
  endtask

  task automatic test_violation();
    @(negedge clk_in_b);
    data_a_i = 8'h11; req_sync_i = ~req_sync_i; ready_i = 1'b0;
    @(negedge clk_in_b);
    tests++;
    if (valid_o !== 1'b1 || data_o !== 8'h11 || err_o !== 1'b0) begin
      fails++; $display("FAIL viol_first_capture: valid %0b data %02h err %0b want 1 11 0", valid_o, data_o, err_o);
    end
    data_a_i = 8'h22; req_sync_i = ~req_sync_i;
    @(negedge clk_in_b);
    err_exp = 1'b1;
    tests++;
    if (err_o !== 1'b1 || valid_o !== 1'b1 || data_o !== 8'h11) begin
      fails++; $display("FAIL viol_flag: err %0b valid %0b data %02h want 1 1 11", err_o, valid_o, data_o);
    end
    ready_i = 1'b1;
    @(negedge clk_in_b);
    ready_i = 1'b0;
    n++;
    tests++;
    if (valid_o !== 1'b0 || data_o !== 8'h11 || ack_b_o !== n[0] || xfer_count_o !== 16'(n)) begin
      fails++; $display("FAIL viol_first_accept: valid %0b data %02h ack %0b cnt %0d want 0 11 %0b %0d",
                        valid_o, data_o, ack_b_o, xfer_count_o, n[0], n);
    end
    @(negedge clk_in_b);
    tests++;
    if (valid_o !== 1'b1 || data_o !== 8'h22 || err_o !== 1'b1) begin
      fails++; $display("FAIL viol_second_capture: valid %0b data %02h err %0b want 1 22 1", valid_o, data_o, err_o);
    end
    ready_i = 1'b1;
    @(negedge clk_in_b);
    ready_i = 1'b0;
    n++;
    tests++;
    if (valid_o !== 1'b0 || ack_b_o !== n[0] || xfer_count_o !== 16'(n) || err_o !== 1'b1) begin
      fails++; $display("FAIL viol_second_accept: valid %0b ack %0b cnt %0d err %0b want 0 %0b %0d 1",
                        valid_o, ack_b_o, xfer_count_o, err_o, n[0], n);
    end
    repeat (2) @(negedge clk_in_b);
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      do_xfer(8'($urandom), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_in_b);
    data_a_i = 8'h5A; req_sync_i = ~req_sync_i; ready_i = 1'b0;
    @(negedge clk_in_b);
    #3 arst_master = 1'b1;
    #1;
    tests++;
    if (valid_o !== 1'b0 || ack_b_o !== 1'b0 || xfer_count_o !== 16'd0 || err_o !== 1'b0 ||
        data_o !== 8'h00 || valid_w !== 1'b0 || count_w !== 4'd0 || err_w !== 1'b0 || data_w !== 8'h00) begin
      fails++; $display("FAIL reset_async: valid %0b ack %0b cnt %0d err %0b data %02h want all 0",
                        valid_o, ack_b_o, xfer_count_o, err_o, data_o);
    end
    n = 0; err_exp = 1'b0;
    req_sync_i = 1'b1;
    @(negedge clk_in_b);
    arst_master = 1'b0;
    @(negedge clk_in_b);
    tests++;
    if (valid_o !== 1'b1 || data_o !== 8'h5A) begin
      fails++; $display("FAIL reset_pending_req: valid %0b data %02h want 1 5a", valid_o, data_o);
    end
    ready_i = 1'b1;
    @(negedge clk_in_b);
    ready_i = 1'b0;
    n++;
    tests++;
    if (valid_o !== 1'b0 || ack_b_o !== 1'b1 || xfer_count_o !== 16'd1) begin
      fails++; $display("FAIL reset_pending_accept: valid %0b ack %0b cnt %0d want 0 1 1", valid_o, ack_b_o, xfer_count_o);
    end
    repeat (2) @(negedge clk_in_b);
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int k = 0; k < 17; k++) do_xfer(8'($urandom), 0, 1'($urandom_range(0, 1)));
    tests++;
    if (count_w !== 4'd1 || xfer_count_o !== 16'd17) begin
      fails++; $display("FAIL wrap: cnt4 %0d cnt16 %0d want 1 17", count_w, xfer_count_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_violation();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
